// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the start/ready/done_tick handshake blocks and the
// BCD conversion datapath.
package bin2bcd_seq_pkg;

    // Handshake FSM encoding, common with the restoring divider.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OP   = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_VALUE     = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the
// next shift, so that the doubled value carries correctly into the next digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= ADD3_THRESHOLD) ? din + ADD3_VALUE : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// cycle, with the same start/ready/done_tick handshake as the divider.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3,
    parameter int CBIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = BCD_DIGIT_W * DIGITS;

    state_t          state_reg, state_next;
    logic [W-1:0]    p2s_reg, p2s_next;
    logic [BW-1:0]   bcd_reg, bcd_next;
    logic [BW-1:0]   bcd_adj;
    logic [CBIT-1:0] n_reg, n_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_reg[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            p2s_reg   <= '0;
            bcd_reg   <= '0;
            n_reg     <= '0;
        end else begin
            state_reg <= state_next;
            p2s_reg   <= p2s_next;
            bcd_reg   <= bcd_next;
            n_reg     <= n_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first; a path
        // that skips an assignment would otherwise infer a latch.
        state_next = state_reg;
        p2s_next   = p2s_reg;
        bcd_next   = bcd_reg;
        n_next     = n_reg;
        ready      = 1'b0;
        done_tick  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    p2s_next   = bin;
                    bcd_next   = '0;
                    n_next     = CBIT'(W);
                    state_next = ST_OP;
                end
            end
            ST_OP: begin
                // Top bit of the adjusted vector is always 0 when the digit
                // count covers the input range, so it is dropped by the shift.
                bcd_next = BW'({bcd_adj, p2s_reg[W-1]});
                p2s_next = p2s_reg << 1;
                n_next   = n_reg - CBIT'(1);
                if (n_reg == CBIT'(1))
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                done_tick  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bcd = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed and random conversions
// against a decimal-digit reference model, plus handshake corner cases.
module tb_bin2bcd_seq;

    localparam int W      = 8;
    localparam int DIGITS = 3;
    localparam int CBIT   = 4;
    localparam int BW     = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  bin;
    logic          ready;
    logic          done_tick;
    logic [BW-1:0] bcd;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    bin2bcd_seq #(.W(W), .DIGITS(DIGITS), .CBIT(CBIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd       (bcd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done_tick === 1'b1) done_cnt++;

    initial begin
        if (!(10**DIGITS > 2**W - 1) || !(2**CBIT > W))
            $fatal(1, "parameter constraint violated: DIGITS or CBIT too small for W");
    end

    // Reference: split the value into decimal digits with plain arithmetic.
    function automatic logic [BW-1:0] bcd_ref(input int v);
        logic [BW-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start pulse; returns in the first cycle after the accept edge.
    task automatic issue(input logic [W-1:0] v);
        bin   = v;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs one conversion. Cycle 1 is the cycle after the accept edge; the
    // done cycle is W+1 and ready stays low through it (W+2 including the
    // start cycle). Returns in the idle cycle right after done.
    task automatic run_conv(input string tag, input int v);
        int cyc, low, d0;
        d0  = done_cnt;
        issue(W'(v));
        cyc = 1;
        low = 0;
        while (done_tick !== 1'b1 && cyc < 64) begin
            if (ready === 1'b0) low++;
            step();
            cyc++;
        end
        if (ready === 1'b0) low++;
        check({tag, "_done_cycle"}, cyc, W + 1);
        check({tag, "_ready_low"}, low, W + 1);
        check({tag, "_bcd"}, 32'(bcd), 32'(bcd_ref(v)));
        step();
        check({tag, "_ready_back"}, 32'(ready), 1);
        check({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, quo, v;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        #1;
        check("rst_ready", 32'(ready), 1);
        check("rst_done",  32'(done_tick), 0);
        check("rst_bcd",   32'(bcd), 0);
        step();
        step();
        rst = 1'b0;
        step();

        run_conv("zero", 0);
        check("zero_literal", 32'(bcd), 32'h000);
        run_conv("max", 255);
        check("max_literal", 32'(bcd), 32'h255);
        run_conv("hundred", 100);
        run_conv("nine", 9);
        run_conv("ten", 10);

        // Divider stand-in: its done pulse drives start, the quotient drives bin.
        quo = 200 / 7;
        run_conv("chain_div", quo);
        check("chain_literal", 32'(bcd), 32'h028);

        // A second start during op is ignored and bin is not re-sampled.
        d0 = done_cnt;
        issue(8'd42);
        step();
        step();
        bin   = 8'd77;
        start = 1'b1;
        step();
        start = 1'b0;
        bin   = 8'd0;
        for (int i = 0; i < 64 && done_tick !== 1'b1; i++) step();
        check("ignore_bcd", 32'(bcd), 32'h042);
        step();
        for (int i = 0; i < 12; i++) step();
        check("ignore_done_count", done_cnt - d0, 1);
        check("ignore_hold_bcd", 32'(bcd), 32'h042);

        // Back-to-back: run_conv returns in the idle cycle after done.
        run_conv("b2b_first", 64);
        run_conv("b2b_13", 13);

        // Reset in op cycle 3 aborts the conversion.
        d0 = done_cnt;
        issue(8'd200);
        step();
        step();
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 1);
        check("abort_bcd",   32'(bcd), 0);
        check("abort_done",  32'(done_tick), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", 32'(ready), 1);
        run_conv("after_abort", 5);

        for (int i = 0; i < 16; i++) begin
            v = int'($urandom_range(0, 2**W - 1));
            run_conv("rand", v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
